// File: rtl/uart_tx_arbiter.sv
// Four-requester arbiter in front of a single UART transmitter.
// Round-robin with per-requester lock for multi-byte messages; registered outputs.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_lock,
    output logic [3:0]  ack,
    output logic        uart_wr,
    output logic [7:0]  uart_data,
    input  logic        uart_busy,
    output logic [1:0]  grant_id,
    output logic        active,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitIdle} state_e;

    state_e     state;
    logic [1:0] pointer;
    logic [3:0] tmo_cnt;
    logic       armed;
    logic       win_valid;
    logic [1:0] win_id;

    // A held lock on the last owner overrides rotation, even if it stalls the bus.
    always_comb begin
        win_valid = 1'b0;
        win_id    = pointer;
        if (req_lock[grant_id]) begin
            win_valid = req[grant_id];
            win_id    = grant_id;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (req[pointer + 2'(k)]) begin
                    win_valid = 1'b1;
                    win_id    = pointer + 2'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= StIdle;
            uart_wr   <= 1'b0;
            uart_data <= 8'h00;
            ack       <= 4'b0000;
            grant_id  <= 2'd0;
            pointer   <= 2'd0;
            active    <= 1'b0;
            err       <= 1'b0;
            tmo_cnt   <= 4'd0;
            armed     <= 1'b0;
        end else begin
            // armed delays the first arbitration to the second edge after reset
            armed   <= 1'b1;
            uart_wr <= 1'b0;
            ack     <= 4'b0000;
            unique case (state)
                StIdle: begin
                    if (armed && (|req) && !uart_busy && win_valid) begin
                        state     <= StIssue;
                        uart_wr   <= 1'b1;
                        uart_data <= req_data[{win_id, 3'b000} +: 8];
                        ack       <= 4'b0001 << win_id;
                        grant_id  <= win_id;
                        pointer   <= win_id + 2'd1;
                        active    <= 1'b1;
                    end
                end
                StIssue: begin
                    state   <= StWaitBusy;
                    tmo_cnt <= 4'd0;
                end
                StWaitBusy: begin
                    if (uart_busy) begin
                        state <= StWaitIdle;
                    end else if (tmo_cnt == 4'(TIMEOUT - 1)) begin
                        state  <= StIdle;
                        active <= 1'b0;
                        err    <= 1'b1;
                    end else if (tmo_cnt != 4'hf) begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                StWaitIdle: begin
                    if (!uart_busy) begin
                        state  <= StIdle;
                        active <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
